// File: rtl/decoder_scan.sv
// Registered 1-of-2^SEL_W decoder with enable, output polarity and an auto-scan sequencer.
// Every output comes from a flop; inputs sampled at an edge show up right after it.
module decoder_scan #(
   parameter int SEL_W      = 2,
   parameter int SCAN_DIV   = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    dir,
   input  logic                    load,
   input  logic [SEL_W-1:0]        sel,
   output logic [(1<<SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]        idx,
   output logic                    step
);

   localparam int OUT_W = 1 << SEL_W;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [OUT_W-1:0] Y_OFF    = {OUT_W{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               step_q, step_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [OUT_W-1:0]   onehot_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         div_q   <= '0;
         step_q  <= 1'b0;
         y_q     <= Y_OFF;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         step_q  <= step_d;
         y_q     <= y_d;
      end
   end

   // State is chosen directly from en/mode each cycle; the actions below key off
   // the state being entered, with state_q only used to detect entry into SCAN.
   always_comb begin
      state_d = ST_IDLE;
      idx_d   = idx_q;
      div_d   = div_q;
      step_d  = 1'b0;

      if (en) begin
         state_d = mode ? ST_SCAN : ST_DIRECT;
      end

      unique case (state_d)
         ST_DIRECT: begin
            idx_d = sel;
            div_d = '0;
         end
         ST_SCAN: begin
            if (load) begin
               idx_d = sel;
               div_d = '0;
            end else if (state_q != ST_SCAN) begin
               div_d = '0;
            end else if (div_q == DIV_LAST) begin
               div_d  = '0;
               idx_d  = dir ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
               step_d = 1'b1;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign onehot_d[gi] = (idx_d == SEL_W'(gi));
   end

   // Polarity is a plain XOR with the deasserted pattern.
   always_comb begin
      y_d = Y_OFF;
      if (state_d != ST_IDLE) begin
         y_d = onehot_d ^ Y_OFF;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign step = step_q;

endmodule
